// File: rtl/clause_coefficient_packer_if.sv
// Literal-stream and packed-clause handshake bundle for clause_coefficient_packer.
// master = loader/consumer side, slave = packer side.
interface clause_coefficient_packer_if #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2
);
    localparam int IW  = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;
    localparam int BW  = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
    localparam int CW  = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT;
    localparam int BCW = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT;
    localparam int IDX = (IW > BW) ? IW : BW;
    localparam int IV  = 2 ** IW;
    localparam int BV  = 2 ** BW;

    logic                    in_start;
    logic                    in_literal_valid;
    logic                    out_literal_ready;
    logic                    in_literal_is_boolean;
    logic [IDX:0]            in_literal_index;
    logic [CW-1:0]           in_literal_coefficient;
    logic                    in_literal_last;
    logic [(IV+1)*CW-1:0]    out_integer_coefficients;
    logic [BV*BCW-1:0]       out_boolean_coefficients;
    logic [IV-1:0]           out_integer_variables;
    logic [BV-1:0]           out_boolean_variables;
    logic                    out_clause_valid;
    logic                    in_clause_ready;
    logic                    out_error;

    modport master (
        output in_start, in_literal_valid, in_literal_is_boolean,
        output in_literal_index, in_literal_coefficient, in_literal_last,
        output in_clause_ready,
        input  out_literal_ready, out_integer_coefficients,
        input  out_boolean_coefficients, out_integer_variables,
        input  out_boolean_variables, out_clause_valid, out_error
    );

    modport slave (
        input  in_start, in_literal_valid, in_literal_is_boolean,
        input  in_literal_index, in_literal_coefficient, in_literal_last,
        input  in_clause_ready,
        output out_literal_ready, out_integer_coefficients,
        output out_boolean_coefficients, out_integer_variables,
        output out_boolean_variables, out_clause_valid, out_error
    );
endinterface

// File: rtl/clause_coefficient_packer.sv
// Packs a serial literal stream into flattened integer/boolean coefficient vectors.
// Optional macro DUPLICATE_LITERAL_CHECK_EN flags any slot written twice in one clause.
module clause_coefficient_packer #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2
) (
    input logic                         in_clk,
    input logic                         in_reset,
    clause_coefficient_packer_if.slave  bus
);
    localparam int IW  = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;
    localparam int BW  = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
    localparam int CW  = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT;
    localparam int BCW = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT;
    localparam int IV  = 2 ** IW;
    localparam int BV  = 2 ** BW;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [IV:0][CW-1:0]     int_buf_q, int_buf_d;
    logic [BV-1:0][BCW-1:0]  bool_buf_q, bool_buf_d;
    logic                    error_q, error_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
`ifdef DUPLICATE_LITERAL_CHECK_EN
    logic [IV:0]             int_wr_q, int_wr_d;
    logic [BV-1:0]           bool_wr_q, bool_wr_d;
`endif

    logic                    restart;
    logic                    accept;
    int                      lit_idx;
    logic [IV-1:0]           int_vars;
    logic [BV-1:0]           bool_vars;

    // Next-state, buffer writes and error tracking for the current cycle.
    always_comb begin
        state_d    = state_q;
        int_buf_d  = int_buf_q;
        bool_buf_d = bool_buf_q;
        error_d    = error_q;
`ifdef DUPLICATE_LITERAL_CHECK_EN
        int_wr_d   = int_wr_q;
        bool_wr_d  = bool_wr_q;
`endif
        lit_idx = int'(bus.in_literal_index);
        // A start while holding a finished clause is ignored so the
        // consumer never sees the clause change under it.
        restart = bus.in_start && (state_q != HOLD);
        accept  = bus.in_literal_valid && ready_q && !restart;

        if (restart) begin
            state_d    = COLLECT;
            int_buf_d  = '0;
            bool_buf_d = '0;
            error_d    = 1'b0;
`ifdef DUPLICATE_LITERAL_CHECK_EN
            int_wr_d   = '0;
            bool_wr_d  = '0;
`endif
        end else if (accept) begin
            if (bus.in_literal_is_boolean) begin
                if (lit_idx >= BV) error_d = 1'b1;
                for (int j = 0; j < BV; j++) begin
                    if (lit_idx == j) begin
                        bool_buf_d[j] = {1'b1, bus.in_literal_coefficient[0]};
`ifdef DUPLICATE_LITERAL_CHECK_EN
                        if (bool_wr_q[j]) error_d = 1'b1;
                        bool_wr_d[j] = 1'b1;
`endif
                    end
                end
            end else begin
                if (lit_idx > IV) error_d = 1'b1;
                for (int i = 0; i <= IV; i++) begin
                    if (lit_idx == i) begin
                        int_buf_d[i] = bus.in_literal_coefficient;
`ifdef DUPLICATE_LITERAL_CHECK_EN
                        if (int_wr_q[i]) error_d = 1'b1;
                        int_wr_d[i] = 1'b1;
`endif
                    end
                end
            end
            if (bus.in_literal_last) state_d = HOLD;
        end else if (state_q == HOLD && bus.in_clause_ready) begin
            state_d = IDLE;
        end

        ready_d = (state_d == COLLECT);
        valid_d = (state_d == HOLD);
    end

    // State, clause buffer and registered handshake outputs.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q    <= IDLE;
            int_buf_q  <= '0;
            bool_buf_q <= '0;
            error_q    <= 1'b0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
`ifdef DUPLICATE_LITERAL_CHECK_EN
            int_wr_q   <= '0;
            bool_wr_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            int_buf_q  <= int_buf_d;
            bool_buf_q <= bool_buf_d;
            error_q    <= error_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
`ifdef DUPLICATE_LITERAL_CHECK_EN
            int_wr_q   <= int_wr_d;
            bool_wr_q  <= bool_wr_d;
`endif
        end
    end

    // Presence masks come from the registered buffer; the constant slot has no variable.
    always_comb begin
        int_vars  = '0;
        bool_vars = '0;
        for (int i = 0; i < IV; i++) int_vars[i] = |int_buf_q[i];
        for (int j = 0; j < BV; j++) bool_vars[j] = bool_buf_q[j][1];
    end

    assign bus.out_literal_ready        = ready_q;
    assign bus.out_clause_valid         = valid_q;
    assign bus.out_error                = error_q;
    assign bus.out_integer_coefficients = int_buf_q;
    assign bus.out_boolean_coefficients = bool_buf_q;
    assign bus.out_integer_variables    = int_vars;
    assign bus.out_boolean_variables    = bool_vars;
endmodule

// File: tb/tb_clause_coefficient_packer.sv
// Scoreboard bench for clause_coefficient_packer with defaults IV=2, BV=2, CW=4.
// Expected clauses are queued by stimulus and checked by a monitor while valid.
module tb_clause_coefficient_packer;
    typedef struct {
        logic [11:0] ic;
        logic [3:0]  bc;
        logic [1:0]  iv;
        logic [1:0]  bv;
        logic        err;
    } exp_t;

`ifdef DUPLICATE_LITERAL_CHECK_EN
    localparam logic DUP = 1'b1;
`else
    localparam logic DUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    clause_coefficient_packer_if bus ();

    clause_coefficient_packer dut (
        .in_clk   (clk),
        .in_reset (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_clause_valid), 0);
        chk({tag, "_lready"}, 32'(bus.out_literal_ready), 0);
        chk({tag, "_error"}, 32'(bus.out_error), 0);
        chk({tag, "_ic"}, 32'(bus.out_integer_coefficients), 0);
        chk({tag, "_bc"}, 32'(bus.out_boolean_coefficients), 0);
        chk({tag, "_iv"}, 32'(bus.out_integer_variables), 0);
        chk({tag, "_bv"}, 32'(bus.out_boolean_variables), 0);
    endtask

    task automatic start();
        bus.in_start = 1'b1;
        cyc();
        bus.in_start = 1'b0;
        chk("lready_after_start", 32'(bus.out_literal_ready), 1);
    endtask

    task automatic send(input logic b, input logic [1:0] idx, input logic [3:0] c, input logic last);
        int n;
        bus.in_literal_valid      = 1'b1;
        bus.in_literal_is_boolean = b;
        bus.in_literal_index      = idx;
        bus.in_literal_coefficient = c;
        bus.in_literal_last       = last;
        n = 0;
        while (!bus.out_literal_ready && n < 20) begin
            cyc();
            n++;
        end
        if (!bus.out_literal_ready) chk("send_timeout", 32'(n), 0);
        cyc();
        bus.in_literal_valid = 1'b0;
        bus.in_literal_last  = 1'b0;
    endtask

    task automatic handoff(input int hold, input exp_t e);
        int n;
        n = 0;
        while (!bus.out_clause_valid && n < 20) begin
            cyc();
            n++;
        end
        chk("valid_latency", 32'(n), 0);
        repeat (hold) cyc();
        bus.in_clause_ready = 1'b1;
        cyc();
        bus.in_clause_ready = 1'b0;
        chk("valid_after_handoff", 32'(bus.out_clause_valid), 0);
        chk("ic_idle_kept", 32'(bus.out_integer_coefficients), 32'(e.ic));
        chk("lready_idle", 32'(bus.out_literal_ready), 0);
    endtask

    // Compare every valid cycle against the queue head; pop on handoff.
    always @(negedge clk) begin
        if (!rst && bus.out_clause_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_clause actual=valid required=idle t=%0t", $time);
            end else begin
                chk("ic", 32'(bus.out_integer_coefficients), 32'(sb[0].ic));
                chk("bc", 32'(bus.out_boolean_coefficients), 32'(sb[0].bc));
                chk("iv", 32'(bus.out_integer_variables), 32'(sb[0].iv));
                chk("bv", 32'(bus.out_boolean_variables), 32'(sb[0].bv));
                chk("err", 32'(bus.out_error), 32'(sb[0].err));
                chk("lready_hold", 32'(bus.out_literal_ready), 0);
                if (bus.in_clause_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bus.in_start = 1'b0;
        bus.in_literal_valid = 1'b0;
        bus.in_literal_is_boolean = 1'b0;
        bus.in_literal_index = '0;
        bus.in_literal_coefficient = '0;
        bus.in_literal_last = 1'b0;
        bus.in_clause_ready = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check_zero("reset");

        // 1: basic clause
        e = '{ic: 12'h503, bc: 4'b1000, iv: 2'b01, bv: 2'b10, err: 1'b0};
        sb.push_back(e);
        start();
        send(1'b0, 2'd0, 4'h3, 1'b0);
        send(1'b0, 2'd2, 4'h5, 1'b0);
        send(1'b1, 2'd1, 4'h0, 1'b1);
        handoff(0, e);

        // 2: held in HOLD for 5 cycles
        e = '{ic: 12'h0C0, bc: 4'b0010, iv: 2'b10, bv: 2'b01, err: 1'b0};
        sb.push_back(e);
        start();
        send(1'b0, 2'd1, 4'hC, 1'b0);
        send(1'b1, 2'd0, 4'h0, 1'b1);
        handoff(5, e);

        // 3: zero coefficient and out-of-range integer index
        e = '{ic: 12'h000, bc: 4'b0000, iv: 2'b00, bv: 2'b00, err: 1'b1};
        sb.push_back(e);
        start();
        send(1'b0, 2'd3, 4'hA, 1'b0);
        send(1'b0, 2'd1, 4'h0, 1'b1);
        handoff(1, e);

        // 4: duplicate write, last wins
        e = '{ic: 12'h007, bc: 4'b0000, iv: 2'b01, bv: 2'b00, err: DUP};
        sb.push_back(e);
        start();
        send(1'b0, 2'd0, 4'h2, 1'b0);
        send(1'b0, 2'd0, 4'h7, 1'b1);
        handoff(1, e);

        // 5: restart mid-clause drops buffer and the concurrent literal
        e = '{ic: 12'h000, bc: 4'b0011, iv: 2'b00, bv: 2'b01, err: 1'b0};
        sb.push_back(e);
        start();
        send(1'b0, 2'd0, 4'h3, 1'b0);
        bus.in_start = 1'b1;
        bus.in_literal_valid = 1'b1;
        bus.in_literal_is_boolean = 1'b0;
        bus.in_literal_index = 2'd1;
        bus.in_literal_coefficient = 4'h9;
        cyc();
        bus.in_start = 1'b0;
        bus.in_literal_valid = 1'b0;
        send(1'b1, 2'd0, 4'h1, 1'b1);
        handoff(1, e);

        // 7: out-of-range boolean index
        e = '{ic: 12'h090, bc: 4'b0000, iv: 2'b10, bv: 2'b00, err: 1'b1};
        sb.push_back(e);
        start();
        send(1'b1, 2'd2, 4'h1, 1'b0);
        send(1'b0, 2'd1, 4'h9, 1'b1);
        handoff(1, e);

        // 8: constant slot only, start during HOLD ignored
        e = '{ic: 12'hF00, bc: 4'b0000, iv: 2'b00, bv: 2'b00, err: 1'b0};
        sb.push_back(e);
        start();
        send(1'b0, 2'd2, 4'hF, 1'b1);
        bus.in_start = 1'b1;
        cyc();
        bus.in_start = 1'b0;
        chk("start_in_hold_valid", 32'(bus.out_clause_valid), 1);
        handoff(1, e);

        // 6a: reset during COLLECT
        start();
        send(1'b0, 2'd0, 4'h3, 1'b0);
        send(1'b1, 2'd3, 4'h1, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_zero("rst_collect");

        // 6b: reset during HOLD
        e = '{ic: 12'h001, bc: 4'b0000, iv: 2'b01, bv: 2'b00, err: 1'b0};
        sb.push_back(e);
        start();
        send(1'b0, 2'd0, 4'h1, 1'b1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sb.delete();
        check_zero("rst_hold");
        cyc();

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
